// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings and defaults for the Pong match controller
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [1:0] PAD_NONE    = 2'b00;
    localparam logic [1:0] PAD_P1      = 2'b01;
    localparam logic [1:0] PAD_P2      = 2'b10;
    localparam logic [1:0] PAD_ILLEGAL = 2'b11;

    // Half of the ball engine's 360-row field.
    localparam int DEFAULT_MID_Y = 180;

endpackage

// File: rtl/pong_hold_timer.sv
// rtl/pong_hold_timer.sv - loadable down-counter shared by the serve and point holds
module pong_hold_timer #(
    parameter int WIDTH = 2
) (
    input  logic             bclk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge bclk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - match sequencer: serve, rally, point hold, scoring, match end
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE         = 7,
    parameter int SERVE_CYCLES      = 60,
    parameter int POINT_HOLD_CYCLES = 120,
    parameter int MID_Y             = DEFAULT_MID_Y
) (
    input  logic       bclk,
    input  logic       reset,
    input  logic       start,
    input  logic       game_end,
    input  logic [1:0] paddle_hit,
    input  logic [9:0] ball_y,
    output logic       ball_reset,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [7:0] rally,
    output logic [1:0] winner,
    output logic       point_sound,
    output logic [2:0] state
);

    localparam int HOLD_MAX = (SERVE_CYCLES > POINT_HOLD_CYCLES) ? SERVE_CYCLES : POINT_HOLD_CYCLES;
    localparam int TW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_CYCLES - 1);
    localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_HOLD_CYCLES - 1);
    localparam logic [3:0]    WIN_V      = 4'(WIN_SCORE);
    localparam logic [9:0]    MID_Y_V    = 10'(MID_Y);

    state_e     state_q, state_d;
    logic       start_q;
    logic       ball_reset_q;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [7:0] rally_q, rally_d;
    logic [1:0] winner_q, winner_d;
    logic       point_sound_q, point_sound_d;

    logic          start_rise;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_en;
    logic          tmr_zero;

    assign start_rise = start & ~start_q;

    pong_hold_timer #(.WIDTH(TW)) u_hold_timer (
        .bclk       (bclk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d       = state_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        rally_d       = rally_q;
        winner_d      = winner_q;
        point_sound_d = 1'b0;
        tmr_load      = 1'b0;
        tmr_load_val  = SERVE_LOAD;
        tmr_en        = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_rise) begin
                    score1_d = '0;
                    score2_d = '0;
                    rally_d  = '0;
                    winner_d = WIN_NONE;
                    tmr_load = 1'b1;
                    state_d  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tmr_zero) state_d = ST_PLAY;
                else          tmr_en  = 1'b1;
            end
            ST_PLAY: begin
                // A miss outranks a same-cycle return: the point ends the rally.
                if (game_end) begin
                    point_sound_d = 1'b1;
                    if (ball_y < MID_Y_V) begin
                        score2_d = score2_q + 4'd1;
                        if (score2_d == WIN_V) winner_d = WIN_P2;
                    end else begin
                        score1_d = score1_q + 4'd1;
                        if (score1_d == WIN_V) winner_d = WIN_P1;
                    end
                    if (winner_d != WIN_NONE) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        tmr_load     = 1'b1;
                        tmr_load_val = POINT_LOAD;
                        state_d      = ST_POINT;
                    end
                end else if ((paddle_hit == PAD_P1) || (paddle_hit == PAD_P2)) begin
                    if (rally_q != 8'hFF) rally_d = rally_q + 8'd1;
                end
            end
            ST_POINT: begin
                if (tmr_zero) begin
                    rally_d  = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_SERVE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            ball_reset_q  <= 1'b1;
            score1_q      <= '0;
            score2_q      <= '0;
            rally_q       <= '0;
            winner_q      <= WIN_NONE;
            point_sound_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            ball_reset_q  <= (state_d != ST_PLAY);
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            rally_q       <= rally_d;
            winner_q      <= winner_d;
            point_sound_q <= point_sound_d;
        end
    end

    assign ball_reset  = ball_reset_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign rally       = rally_q;
    assign winner      = winner_q;
    assign point_sound = point_sound_q;
    assign state       = state_q;

endmodule
